// File: rtl/pixel_filter_pipe.sv
// pixel_filter_pipe: three-stage RGB888 -> RGB444 video filter with a per-frame mode latch.
// The hs/vs/valid outputs are delayed so that they leave the block aligned with the colour they belong to.
module pixel_filter_pipe #(
  parameter int LATENCY = 3,
  parameter int LUMA_R  = 77,
  parameter int LUMA_G  = 150,
  parameter int LUMA_B  = 29
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] pix_in,
  input  logic        pix_valid_in,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic [11:0] sw,
  output logic [11:0] vga_rgb,
  output logic        hs_out,
  output logic        vs_out,
  output logic        pix_valid_out
);

  // Mode latch state
  logic [3:0]  mode_active_reg;
  logic [7:0]  thr_active_reg;
  logic        vs_prev_reg;
  logic        vs_fall;

  // Stage 1
  logic [15:0] luma_sum;
  logic [7:0]  gray_next;
  logic [23:0] s1_pix_reg;
  logic [7:0]  s1_gray_reg;
  logic        s1_valid_reg;
  logic [3:0]  s1_mode_reg;
  logic [7:0]  s1_thr_reg;

  // Stage 2
  logic [7:0]  prev_gray_reg;
  logic [7:0]  ref_gray;
  logic [7:0]  gray_diff;
  logic [7:0]  edge_val;
  logic [7:0]  thr_val;
  logic [23:0] filt_rgb;
  logic [23:0] rot_rgb;
  logic [11:0] quant_next;
  logic [11:0] s2_rgb_reg;
  logic        s2_valid_reg;

  // Stage 3 and sync delay lines
  logic [11:0]        vga_rgb_reg;
  logic               valid_out_reg;
  logic [LATENCY-1:0] hs_pipe_reg;
  logic [LATENCY-1:0] vs_pipe_reg;

  assign vs_fall = !vs_in && vs_prev_reg;

  // Latch switches only at the start of vertical sync so a frame is never rendered with two modes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_active_reg <= 4'b0000;
      thr_active_reg  <= 8'h00;
      vs_prev_reg     <= 1'b1;
    end else begin
      vs_prev_reg <= vs_in;
      if (vs_fall) begin
        mode_active_reg <= sw[3:0];
        thr_active_reg  <= sw[11:4];
      end
    end
  end

  // Luma weights sum to 256, so the top byte of the 16-bit sum is the 8-bit gray level
  always_comb begin
    luma_sum  = 16'(LUMA_R) * 16'(pix_in[23:16])
              + 16'(LUMA_G) * 16'(pix_in[15:8])
              + 16'(LUMA_B) * 16'(pix_in[7:0]);
    gray_next = 8'(luma_sum >> 8);
  end

  // Stage 1: capture pixel and gray; the mode travels with the pixel so a latch on this cycle hits only later pixels
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_pix_reg   <= 24'h000000;
      s1_gray_reg  <= 8'h00;
      s1_valid_reg <= 1'b0;
      s1_mode_reg  <= 4'b0000;
      s1_thr_reg   <= 8'h00;
    end else begin
      s1_pix_reg   <= pix_in;
      s1_gray_reg  <= gray_next;
      s1_valid_reg <= pix_valid_in;
      s1_mode_reg  <= mode_active_reg;
      s1_thr_reg   <= thr_active_reg;
    end
  end

  // Stage 2 filter: select the filter, then apply the optional {R,G,B} -> {G,B,R} rotate
  always_comb begin
    // At line start the previous gray is taken to be the current one, so the edge output is zero
    ref_gray  = s2_valid_reg ? prev_gray_reg : s1_gray_reg;
    gray_diff = (s1_gray_reg >= ref_gray) ? (s1_gray_reg - ref_gray) : (ref_gray - s1_gray_reg);
    edge_val  = gray_diff[7] ? 8'hFF : {gray_diff[6:0], 1'b0};
    thr_val   = (s1_gray_reg >= s1_thr_reg) ? 8'hFF : 8'h00;
    case (s1_mode_reg[2:0])
      3'd1:    filt_rgb = {s1_gray_reg, s1_gray_reg, s1_gray_reg};
      3'd2:    filt_rgb = ~s1_pix_reg;
      3'd3:    filt_rgb = {edge_val, edge_val, edge_val};
      3'd4:    filt_rgb = {thr_val, thr_val, thr_val};
      default: filt_rgb = s1_pix_reg;
    endcase
    rot_rgb = s1_mode_reg[3] ? {filt_rgb[15:0], filt_rgb[23:16]} : filt_rgb;
  end

  // Quantise each channel to its upper nibble (truncation, no rounding)
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_quant
      assign quant_next[gi*4 +: 4] = rot_rgb[gi*8+4 +: 4];
    end
  endgenerate

  // Stage 2 registers plus the edge-filter history, which only advances on valid pixels
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_rgb_reg    <= 12'h000;
      s2_valid_reg  <= 1'b0;
      prev_gray_reg <= 8'h00;
    end else begin
      s2_rgb_reg   <= quant_next;
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        prev_gray_reg <= s1_gray_reg;
      end
    end
  end

  // Stage 3: blank colour outside the visible area
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vga_rgb_reg   <= 12'h000;
      valid_out_reg <= 1'b0;
    end else begin
      vga_rgb_reg   <= s2_valid_reg ? s2_rgb_reg : 12'h000;
      valid_out_reg <= s2_valid_reg;
    end
  end

  // Sync delay lines; they reset to 1 so the sync outputs come out of reset inactive
  generate
    for (genvar gi = 0; gi < LATENCY; gi++) begin : g_sync
      // One sync delay stage
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          hs_pipe_reg[gi] <= 1'b1;
          vs_pipe_reg[gi] <= 1'b1;
        end else if (gi == 0) begin
          hs_pipe_reg[gi] <= hs_in;
          vs_pipe_reg[gi] <= vs_in;
        end else begin
          hs_pipe_reg[gi] <= hs_pipe_reg[(gi == 0) ? 0 : gi-1];
          vs_pipe_reg[gi] <= vs_pipe_reg[(gi == 0) ? 0 : gi-1];
        end
      end
    end
  endgenerate

  assign vga_rgb       = vga_rgb_reg;
  assign pix_valid_out = valid_out_reg;
  assign hs_out        = hs_pipe_reg[LATENCY-1];
  assign vs_out        = vs_pipe_reg[LATENCY-1];

endmodule

// File: tb/tb_pixel_filter_pipe.sv
// Bench for pixel_filter_pipe: a per-pixel reference model checks every cycle, and a table plus
// short directed sequences check the documented example values.
module tb_pixel_filter_pipe;

  localparam int LR = 77;
  localparam int LG = 150;
  localparam int LB = 29;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] pix_in;
  logic        pix_valid_in;
  logic        hs_in;
  logic        vs_in;
  logic [11:0] sw;
  logic [11:0] vga_rgb;
  logic        hs_out;
  logic        vs_out;
  logic        pix_valid_out;

  always #5 clk = ~clk;

  pixel_filter_pipe #(.LATENCY(3), .LUMA_R(LR), .LUMA_G(LG), .LUMA_B(LB)) dut (
    .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_valid_in(pix_valid_in),
    .hs_in(hs_in), .vs_in(vs_in), .sw(sw), .vga_rgb(vga_rgb),
    .hs_out(hs_out), .vs_out(vs_out), .pix_valid_out(pix_valid_out)
  );

  typedef struct {
    logic [11:0] rgb;
    logic        v;
    logic        h;
    logic        vs;
  } exp_t;

  typedef struct {
    string       name;
    logic [11:0] swv;
    logic        valid;
    logic [23:0] pix;
    logic [11:0] want;
  } vec_t;

  localparam exp_t RST_EXP = '{rgb: 12'h000, v: 1'b0, h: 1'b1, vs: 1'b1};

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic [11:0] rgb_log [0:8191];
  logic [11:0] cur_sw = 12'h000;

  // Reference model state: per-frame mode, last valid gray, previous valid, previous vs
  int   m_mode = 0;
  int   m_thr  = 0;
  int   m_pg   = 0;
  logic m_pv   = 1'b0;
  logic m_vsp  = 1'b1;

  // Expected output for one input pixel; advances the model state by one pixel
  function automatic exp_t ref_pixel(input logic v, input logic h, input logic vv,
                                     input logic [11:0] s, input logic [23:0] p);
    int r8, g8, b8, gy, d, t;
    int o[3];
    int tmp[3];
    exp_t e;
    r8 = int'(p[23:16]);
    g8 = int'(p[15:8]);
    b8 = int'(p[7:0]);
    gy = (LR * r8 + LG * g8 + LB * b8) / 256;
    case (m_mode % 8)
      1: o = '{gy, gy, gy};
      2: o = '{255 - r8, 255 - g8, 255 - b8};
      3: begin
        d = m_pv ? ((gy > m_pg) ? gy - m_pg : m_pg - gy) : 0;
        t = (2 * d > 255) ? 255 : 2 * d;
        o = '{t, t, t};
      end
      4: begin
        t = (gy >= m_thr) ? 255 : 0;
        o = '{t, t, t};
      end
      default: o = '{r8, g8, b8};
    endcase
    if (m_mode >= 8) begin
      tmp = '{o[1], o[2], o[0]};
      o = tmp;
    end
    e.rgb = v ? {4'(o[0] / 16), 4'(o[1] / 16), 4'(o[2] / 16)} : 12'h000;
    e.v  = v;
    e.h  = h;
    e.vs = vv;
    if (v) m_pg = gy;
    m_pv = v;
    if (!vv && m_vsp) begin
      m_mode = int'(s[3:0]);
      m_thr  = int'(s[11:4]);
    end
    m_vsp = vv;
    return e;
  endfunction

  // One clock: drive inputs, advance the model, compare all outputs just after the edge
  task automatic step(input logic r, input logic v, input logic h, input logic vv,
                      input logic [11:0] s, input logic [23:0] p);
    exp_t x;
    rst_n = r; pix_valid_in = v; hs_in = h; vs_in = vv; sw = s; pix_in = p;
    @(posedge clk);
    if (!r) begin
      q.delete();
      q.push_back(RST_EXP);
      q.push_back(RST_EXP);
      m_mode = 0; m_thr = 0; m_pg = 0; m_pv = 1'b0; m_vsp = 1'b1;
      x = RST_EXP;
    end else begin
      q.push_back(ref_pixel(v, h, vv, s, p));
      x = q.pop_front();
    end
    #1;
    rgb_log[cyc % 8192] = vga_rgb;
    n_cmp++;
    if ({vga_rgb, pix_valid_out, hs_out, vs_out} !== {x.rgb, x.v, x.h, x.vs}) begin
      n_bad++;
      $display("FAIL pipe cyc=%0d got rgb=%h v=%b hs=%b vs=%b want rgb=%h v=%b hs=%b vs=%b",
               cyc, vga_rgb, pix_valid_out, hs_out, vs_out, x.rgb, x.v, x.h, x.vs);
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b1, 1'b1, cur_sw, 24'h000000);
  endtask

  // One vs_in low pulse so the switches are latched
  task automatic latch(input logic [11:0] s);
    cur_sw = s;
    step(1'b1, 1'b0, 1'b1, 1'b1, s, 24'h0);
    step(1'b1, 1'b0, 1'b1, 1'b0, s, 24'h0);
    step(1'b1, 1'b0, 1'b1, 1'b1, s, 24'h0);
  endtask

  task automatic pix(input logic [23:0] p, output int c);
    c = cyc;
    step(1'b1, 1'b1, 1'b1, 1'b1, cur_sw, p);
  endtask

  // Compare the colour produced for the input applied at step c against a fixed value
  task automatic check_rgb(input string name, input int c, input logic [11:0] want);
    logic [11:0] got;
    got = rgb_log[(c + 2) % 8192];
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end else begin
      $display("TXN %s rgb=%h", name, got);
    end
  endtask

  vec_t tbl[12];
  int   c0, c1, c2, c3, c4;

  initial begin
    tbl[0]  = '{"pass_abcdef",  12'h000, 1'b1, 24'hABCDEF, 12'hACE};
    tbl[1]  = '{"invalid_zero", 12'h000, 1'b0, 24'hABCDEF, 12'h000};
    tbl[2]  = '{"gray_red",     12'h001, 1'b1, 24'hFF0000, 12'h444};
    tbl[3]  = '{"invert",       12'h002, 1'b1, 24'h123456, 12'hECA};
    tbl[4]  = '{"invert_rot",   12'h00A, 1'b1, 24'h123456, 12'hCAE};
    tbl[5]  = '{"thr_white",    12'h804, 1'b1, 24'hFFFFFF, 12'hFFF};
    tbl[6]  = '{"thr_7f",       12'h804, 1'b1, 24'h7F7F7F, 12'h000};
    tbl[7]  = '{"thr_80",       12'h804, 1'b1, 24'h808080, 12'hFFF};
    tbl[8]  = '{"thr_black",    12'h804, 1'b1, 24'h000000, 12'h000};
    tbl[9]  = '{"mode5_pass",   12'h005, 1'b1, 24'h123456, 12'h135};
    tbl[10] = '{"pass_rot",     12'h008, 1'b1, 24'h123456, 12'h351};
    tbl[11] = '{"gray_white",   12'h001, 1'b1, 24'hFFFFFF, 12'hFFF};

    // Reset held with random inputs
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 12'($urandom), 24'($urandom));
    n_cmp++;
    if ({vga_rgb, pix_valid_out, hs_out, vs_out} !== {12'h000, 1'b0, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_vals got=%h/%b/%b/%b want=000/0/1/1", vga_rgb, pix_valid_out, hs_out, vs_out);
    end else $display("TXN reset_vals ok");
    cur_sw = 12'h002;
    idle(1);
    pix(24'h123456, c0);
    idle(3);
    check_rgb("post_reset_pass", c0, 12'h135);

    // Table of single-pixel cases, each after its own latch
    for (int i = 0; i < 12; i++) begin
      latch(tbl[i].swv);
      idle(1);
      c0 = cyc;
      step(1'b1, tbl[i].valid, 1'b1, 1'b1, cur_sw, tbl[i].pix);
      idle(3);
      check_rgb(tbl[i].name, c0, tbl[i].want);
    end

    // Edge filter along a line, then a gap restarts the line
    latch(12'h003);
    idle(1);
    pix(24'h101010, c0);
    pix(24'h303030, c1);
    pix(24'h000000, c2);
    pix(24'hFFFFFF, c3);
    idle(1);
    pix(24'h808080, c4);
    idle(3);
    check_rgb("edge_start", c0, 12'h000);
    check_rgb("edge_10_30", c1, 12'h444);
    check_rgb("edge_30_00", c2, 12'h666);
    check_rgb("edge_sat",   c3, 12'hFFF);
    check_rgb("edge_gap",   c4, 12'h000);

    // Switch change mid-frame is ignored until the next vs fall
    latch(12'h000);
    cur_sw = 12'h002;
    idle(2);
    pix(24'h123456, c0);
    idle(3);
    check_rgb("midframe_hold", c0, 12'h135);
    latch(12'h002);
    pix(24'h123456, c0);
    idle(3);
    check_rgb("after_vs_inv", c0, 12'hECA);

    // Valid pixel on the vs fall uses the old mode; the next pixel uses the new one
    latch(12'h000);
    cur_sw = 12'h002;
    idle(1);
    c0 = cyc;
    step(1'b1, 1'b1, 1'b1, 1'b0, cur_sw, 24'h123456);
    pix(24'h123456, c1);
    idle(3);
    check_rgb("vsfall_old", c0, 12'h135);
    check_rgb("vsfall_new", c1, 12'hECA);

    // Reset mid-line returns to passthrough
    latch(12'h002);
    pix(24'h808080, c0);
    step(1'b0, 1'b1, 1'b1, 1'b1, cur_sw, 24'hFFFFFF);
    pix(24'h123456, c1);
    idle(3);
    check_rgb("reset_midline", c1, 12'h135);

    // Randomised frames with occasional resets, checked by the model every cycle
    for (int k = 0; k < 3000; k++) begin
      logic vv, h, v, r;
      if (k % 50 == 0) cur_sw = 12'($urandom);
      vv = ((k % 300) < 3) ? 1'b0 : 1'b1;
      h  = ((k % 40) < 4) ? 1'b0 : 1'b1;
      v  = (h && vv) ? ($urandom_range(0, 4) != 0) : 1'b0;
      r  = ($urandom_range(0, 699) != 0);
      step(r, v, h, vv, cur_sw, 24'($urandom));
    end
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
